// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared vending machine coin vocabulary and change width
package vm_pkg;

   localparam int CHANGE_W = 6;

   // Coin codes shared by the acceptor, the vending FSM and the payout hopper
   typedef enum logic [2:0] {
      NO_COIN    = 3'b000,
      NICKEL     = 3'b001,
      DIME       = 3'b010,
      QUARTER    = 3'b011,
      HALFDOLLAR = 3'b100,
      DOLLAR     = 3'b101
   } coin_t;

   // Coin values expressed in nickels
   localparam logic [CHANGE_W-1:0] VAL_NICKEL     = 6'd1;
   localparam logic [CHANGE_W-1:0] VAL_DIME       = 6'd2;
   localparam logic [CHANGE_W-1:0] VAL_QUARTER    = 6'd5;
   localparam logic [CHANGE_W-1:0] VAL_HALFDOLLAR = 6'd10;
   localparam logic [CHANGE_W-1:0] VAL_DOLLAR     = 6'd20;

   // Value in nickels of a coin code; anything that is not a coin is worth nothing
   function automatic logic [CHANGE_W-1:0] coin_value(input logic [2:0] code);
      case (code)
         NICKEL:     coin_value = VAL_NICKEL;
         DIME:       coin_value = VAL_DIME;
         QUARTER:    coin_value = VAL_QUARTER;
         HALFDOLLAR: coin_value = VAL_HALFDOLLAR;
         DOLLAR:     coin_value = VAL_DOLLAR;
         default:    coin_value = '0;
      endcase
   endfunction

endpackage

// File: rtl/coin_select.sv
// rtl/coin_select.sv - greedy largest-coin selector (DOLLAR gated by CHANGE_DOLLAR_COIN_EN)
module coin_select
   import vm_pkg::*;
(
   input  logic [5:0] amount,
   output logic [2:0] coin,
   output logic [5:0] value
);

   // Ascending checks: the last coin that still fits wins, giving the largest one
   always_comb begin
      coin = NO_COIN;
      if (amount >= VAL_NICKEL)     coin = NICKEL;
      if (amount >= VAL_DIME)       coin = DIME;
      if (amount >= VAL_QUARTER)    coin = QUARTER;
      if (amount >= VAL_HALFDOLLAR) coin = HALFDOLLAR;
`ifdef CHANGE_DOLLAR_COIN_EN
      if (amount >= VAL_DOLLAR)     coin = DOLLAR;
`endif
      value = coin_value(coin);
   end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - one-coin-at-a-time change payout FSM (option: CHANGE_DOLLAR_COIN_EN)
module change_dispenser
   import vm_pkg::*;
#(
   parameter int GAP_CYCLES = 3
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [5:0] change,
   input  logic       hopper_ready,
   output logic       eject,
   output logic [2:0] coin_out,
   output logic [5:0] remaining,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_EJECT,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] gap_cnt;
   logic [2:0] sel_coin;
   logic [5:0] sel_value;
   logic       gap_end;

   // Selector looks at the live balance; it is stable from SELECT through EJECT
   coin_select u_coin_select (
      .amount (remaining),
      .coin   (sel_coin),
      .value  (sel_value)
   );

   assign gap_end = (gap_cnt == GAP_LAST);

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic; the GAP exit sees the balance already reduced by the last coin
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (load) state_next = (change == '0) ? S_DONE : S_SELECT;
         end
         S_SELECT: begin
            if (hopper_ready) state_next = S_EJECT;
         end
         S_EJECT: begin
            state_next = S_GAP;
         end
         S_GAP: begin
            if (gap_end) state_next = (remaining == '0) ? S_DONE : S_SELECT;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Balance, gap counter and registered outputs derived from the upcoming state
   always_ff @(posedge clock) begin
      if (reset) begin
         eject     <= 1'b0;
         coin_out  <= NO_COIN;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         gap_cnt   <= '0;
      end else begin
         eject    <= (state_next == S_EJECT);
         coin_out <= (state_next == S_EJECT) ? sel_coin : NO_COIN;
         busy     <= (state_next != S_IDLE);
         done     <= (state_next == S_DONE);

         if (state == S_IDLE && load)
            remaining <= change;
         else if (state == S_EJECT)
            remaining <= remaining - sel_value;

         if (state == S_GAP && !gap_end)
            gap_cnt <= gap_cnt + 4'd1;
         else
            gap_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser
module tb_change_dispenser;

   localparam int G = 3;

`ifdef CHANGE_DOLLAR_COIN_EN
   localparam int ND = 5;
   int dv[5] = '{20, 10, 5, 2, 1};
   int dc[5] = '{5, 4, 3, 2, 1};
`else
   localparam int ND = 4;
   int dv[4] = '{10, 5, 2, 1};
   int dc[4] = '{4, 3, 2, 1};
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [5:0] change = '0;
   logic       hopper_ready = 1'b0;
   logic       eject;
   logic [2:0] coin_out;
   logic [5:0] remaining;
   logic       busy;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   change_dispenser #(.GAP_CYCLES(G)) dut (
      .clock        (clock),
      .reset        (reset),
      .load         (load),
      .change       (change),
      .hopper_ready (hopper_ready),
      .eject        (eject),
      .coin_out     (coin_out),
      .remaining    (remaining),
      .busy         (busy),
      .done         (done)
   );

   always #5 clock = ~clock;

   // Payout of amt; mode 0 ready always, 1 random ready, 2 ready low for cycles 0..5
   task automatic run_txn(input int amt, input int mode, input bit noise);
      int rdy[256];
      int cc[$];
      int cv[$];
      int ej[$];
      int rem, t, t_sel, done_c, k, paid;
      int exp_ej, exp_coin, exp_rem, exp_busy, exp_done;
      for (int i = 0; i < 256; i++) begin
         case (mode)
            0:       rdy[i] = 1;
            1:       rdy[i] = (i > 120) ? 1 : int'($urandom_range(0, 3) != 0);
            default: rdy[i] = (i <= 5) ? 0 : 1;
         endcase
      end
      rem = amt;
      while (rem > 0) begin
         for (int d = 0; d < ND; d++) begin
            if (dv[d] <= rem) begin
               cc.push_back(dc[d]);
               cv.push_back(dv[d]);
               rem -= dv[d];
               break;
            end
         end
      end
      t_sel = 1;
      for (int i = 0; i < cc.size(); i++) begin
         t = t_sel;
         while (rdy[t] == 0 && t < 250) t++;
         ej.push_back(t + 1);
         t_sel = t + 2 + G;
      end
      done_c = (cc.size() == 0) ? 1 : ej[ej.size()-1] + G + 1;
      k = 0;
      paid = 0;
      for (int c = 0; c <= done_c; c++) begin
         @(negedge clock);
         if (c == 0) begin
            load = 1'b1;
            change = 6'(amt);
         end else begin
            load = noise && ($urandom_range(0, 2) == 0);
            change = 6'($urandom);
         end
         hopper_ready = (rdy[c] != 0);
         @(posedge clock);
         #1;
         exp_ej   = (k < ej.size() && ej[k] == c + 1) ? 1 : 0;
         exp_coin = (exp_ej != 0) ? cc[k] : 0;
         exp_rem  = amt - paid;
         exp_busy = (c + 1 <= done_c) ? 1 : 0;
         exp_done = (c + 1 == done_c) ? 1 : 0;
         n_vec += 5;
         if (eject !== 1'(exp_ej)) begin
            n_err++;
            $display("FAIL eject amt=%0d cycle=%0d got=%b want=%0d", amt, c + 1, eject, exp_ej);
         end
         if (coin_out !== 3'(exp_coin)) begin
            n_err++;
            $display("FAIL coin_out amt=%0d cycle=%0d got=%0d want=%0d", amt, c + 1, coin_out, exp_coin);
         end
         if (remaining !== 6'(exp_rem)) begin
            n_err++;
            $display("FAIL remaining amt=%0d cycle=%0d got=%0d want=%0d", amt, c + 1, remaining, exp_rem);
         end
         if (busy !== 1'(exp_busy)) begin
            n_err++;
            $display("FAIL busy amt=%0d cycle=%0d got=%b want=%0d", amt, c + 1, busy, exp_busy);
         end
         if (done !== 1'(exp_done)) begin
            n_err++;
            $display("FAIL done amt=%0d cycle=%0d got=%b want=%0d", amt, c + 1, done, exp_done);
         end
         if (exp_ej != 0) begin
            paid += cv[k];
            k++;
         end
      end
      @(negedge clock);
      load = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      n_vec += 5;
      if (eject !== 1'b0) begin
         n_err++;
         $display("FAIL %s eject got=%b want=0", tag, eject);
      end
      if (coin_out !== 3'b000) begin
         n_err++;
         $display("FAIL %s coin_out got=%0d want=0", tag, coin_out);
      end
      if (remaining !== 6'd0) begin
         n_err++;
         $display("FAIL %s remaining got=%0d want=0", tag, remaining);
      end
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s busy got=%b want=0", tag, busy);
      end
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL %s done got=%b want=0", tag, done);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      load = 1'b1;
      change = 6'd33;
      hopper_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check_reset_values("reset");
      @(negedge clock);
      reset = 1'b0;
      load = 1'b0;
   endtask

   task automatic test_example_75c();
      run_txn(15, 0, 1'b0);
   endtask

   task automatic test_twenty();
      run_txn(20, 0, 1'b0);
   endtask

   task automatic test_zero();
      run_txn(0, 0, 1'b0);
   endtask

   task automatic test_max();
      run_txn(63, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_txn(2, 2, 1'b1);
      run_txn(9, 2, 1'b1);
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         load = (c == 0);
         change = 6'd15;
         hopper_ready = 1'b1;
         @(posedge clock);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_reset_values("reset_mid");
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clock);
         #1;
         check_reset_values("after_abort");
      end
   endtask

   task automatic test_back_to_back();
      run_txn(7, 0, 1'b0);
      run_txn(31, 0, 1'b0);
      run_txn(0, 0, 1'b0);
      run_txn(1, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++)
         run_txn(int'($urandom_range(0, 63)), 1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_example_75c();
      test_twenty();
      test_zero();
      test_max();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
